// File: rtl/led_axi_slave.sv
// AXI4-Lite slave holding the LED pattern, brightness and write-count registers.
// Define LED_PWM_EN to add the brightness register and PWM dimming of led.
module led_axi_slave #(
    parameter logic [15:0] RESET_LEDS = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [15:0] led
);
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic        aw_held;
    logic        w_held;
    logic [1:0]  aw_addr_q;
    logic [15:0] w_data_q;
    logic [1:0]  w_strb_q;
    logic [15:0] pattern;
    logic [31:0] wr_count;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    logic        wr_ok;
    logic [1:0]  addr_e;
    logic [15:0] data_e;
    logic [1:0]  strb_e;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        unused_bits;
`ifdef LED_PWM_EN
    logic [7:0]  brightness;
    logic [7:0]  pwm_cnt;
`endif

    assign unused_bits = ^{S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0], S_AXI_AWPROT,
                           S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2],
                           S_AXI_ARADDR[31:4], S_AXI_ARADDR[1:0], S_AXI_ARPROT};

    // A handshake on the commit edge bypasses the holding registers
    always_comb begin
        aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs   = S_AXI_WVALID && S_AXI_WREADY;
        ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
        addr_e = aw_hs ? S_AXI_AWADDR[3:2] : aw_addr_q;
        data_e = w_hs ? S_AXI_WDATA[15:0] : w_data_q;
        strb_e = w_hs ? S_AXI_WSTRB[1:0] : w_strb_q;
        commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
        wr_ok  = !addr_e[1];
    end

    always_comb begin
        rd_data = 32'h0;
        rd_resp = 2'b00;
        unique case (S_AXI_ARADDR[3:2])
            2'd0: rd_data = {16'h0, pattern};
`ifdef LED_PWM_EN
            2'd1: rd_data = {24'h0, brightness};
`else
            2'd1: rd_data = 32'h0;
`endif
            2'd2: rd_data = wr_count;
            2'd3: rd_resp = 2'b10;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= 2'b00;
            w_data_q      <= 16'h0;
            w_strb_q      <= 2'b00;
            pattern       <= RESET_LEDS;
            wr_count      <= 32'h0;
`ifdef LED_PWM_EN
            brightness    <= 8'hFF;
`endif
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= S_AXI_AWADDR[3:2];
                    end
                    if (w_hs) begin
                        w_held   <= 1'b1;
                        w_data_q <= S_AXI_WDATA[15:0];
                        w_strb_q <= S_AXI_WSTRB[1:0];
                    end
                    if (commit) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                        S_AXI_BRESP   <= wr_ok ? 2'b00 : 2'b10;
                        w_state       <= W_RESP;
                        if (wr_ok)
                            wr_count <= wr_count + 32'd1;
                        if (addr_e == 2'd0) begin
                            if (strb_e[0]) pattern[7:0]  <= data_e[7:0];
                            if (strb_e[1]) pattern[15:8] <= data_e[15:8];
                        end
`ifdef LED_PWM_EN
                        if (addr_e == 2'd1 && strb_e[0])
                            brightness <= data_e[7:0];
`endif
                    end else begin
                        S_AXI_AWREADY <= !(aw_held || aw_hs);
                        S_AXI_WREADY  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (S_AXI_BVALID && S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= 32'h0;
            S_AXI_RRESP   <= 2'b00;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        S_AXI_RDATA   <= rd_data;
                        S_AXI_RRESP   <= rd_resp;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                        r_state       <= R_RESP;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RVALID && S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef LED_PWM_EN
    // 255-cycle period so brightness 0xFF is always on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= 8'h0;
            led     <= RESET_LEDS;
        end else begin
            pwm_cnt <= (pwm_cnt == 8'd254) ? 8'h0 : pwm_cnt + 8'd1;
            led     <= pattern & {16{pwm_cnt < brightness}};
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            led <= RESET_LEDS;
        else
            led <= pattern;
    end
`endif

endmodule

// File: tb/tb_led_axi_slave.sv
// Scoreboard bench for led_axi_slave: randomized AXI-Lite traffic against a
// register-level reference model, plus directed reset, stall and PWM cases.
module tb_led_axi_slave;
    localparam logic [15:0] RESET_LEDS = 16'h0000;
`ifdef LED_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [15:0] led;

    always #5 clk = ~clk;

    led_axi_slave #(.RESET_LEDS(RESET_LEDS)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .led(led)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [15:0] m_pat;
    logic [7:0]  m_bri;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        case (a[3:2])
            2'd0: begin
                if (s[0]) m_pat[7:0] = d[7:0];
                if (s[1]) m_pat[15:8] = d[15:8];
                m_cnt = m_cnt + 1;
                return 2'b00;
            end
            2'd1: begin
                if (PWM && s[0]) m_bri = d[7:0];
                m_cnt = m_cnt + 1;
                return 2'b00;
            end
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        case (a[3:2])
            2'd0: return {2'b00, 16'h0, m_pat};
            2'd1: return {2'b00, PWM ? {24'h0, m_bri} : 32'h0};
            2'd2: return {2'b00, m_cnt};
            default: return {2'b10, 32'h0};
        endcase
    endfunction

    always @(negedge clk) begin : b_mon
        logic [1:0] e;
        if (bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", bq.size(), 1);
            else begin
                e = bq.pop_front();
                chk("bresp", {30'h0, bresp}, {30'h0, e});
            end
        end
    end

    always @(negedge clk) begin : r_mon
        logic [33:0] e;
        if (rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", rq.size(), 1);
            else begin
                e = rq.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("rresp", {30'h0, rresp}, {30'h0, e[33:32]});
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input bit stall);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_f;
        bit w_f;
        int c = 0;
        bq.push_back(model_write(a, d, s));
        bready = !stall;
        awaddr = a;
        wdata = d;
        wstrb = s;
        while (!(aw_done && w_done) && c < 40) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid = !w_done && (c >= w_dly);
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f = wvalid && wready;
            @(posedge clk);
            #1;
            aw_done |= aw_f;
            w_done |= w_f;
            c++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        chk("w_handshake", {30'h0, aw_done, w_done}, 32'h3);
        chk("b_latency", {31'h0, bvalid}, 32'h1);
        if (stall) begin
            // offer a second write that must be refused while B is pending
            awvalid = 1'b1;
            wvalid = 1'b1;
            wdata = 32'hFFFF_FFFF;
            repeat (5) begin
                @(negedge clk);
                chk("stall_hold", {29'h0, bvalid, awready, wready}, 32'h4);
            end
            @(posedge clk);
            #1;
            awvalid = 1'b0;
            wvalid = 1'b0;
            bready = 1'b1;
        end
        c = 0;
        while (bq.size() != 0 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("b_drain", bq.size(), 0);
`ifndef LED_PWM_EN
        chk("led", {16'h0, led}, {16'h0, m_pat});
`endif
    endtask

    task automatic do_read(input logic [31:0] a);
        bit done = 0;
        bit f;
        int c = 0;
        rq.push_back(model_read(a));
        araddr = a;
        rready = 1'b1;
        while (!done && c < 40) begin
            arvalid = 1'b1;
            @(negedge clk);
            f = arvalid && arready;
            @(posedge clk);
            #1;
            done = f;
            c++;
        end
        arvalid = 1'b0;
        chk("ar_handshake", {31'h0, done}, 32'h1);
        chk("r_latency", {31'h0, rvalid}, 32'h1);
        c = 0;
        while (rq.size() != 0 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("r_drain", rq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        bit f;
        m_pat = RESET_LEDS;
        m_bri = 8'hFF;
        m_cnt = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {29'h0, awready, wready, arready}, 32'h0);
        chk("rst_valid", {26'h0, bvalid, rvalid, bresp, rresp}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_led", {16'h0, led}, {16'h0, RESET_LEDS});
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {29'h0, awready, wready, arready}, 32'h7);

        do_read(32'h0);
        do_read(32'h4);
        do_read(32'h8);
        do_write(32'h0, 32'hAAAA, 4'hF, 0, 0, 0);
        do_write(32'h0, 32'h5555, 4'hF, 0, 0, 0);
        do_read(32'h8);
        do_write(32'h0, 32'h1234, 4'b0010, 3, 0, 0);
        do_read(32'h0);
        do_write(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(32'hC);
        do_read(32'h8);
        do_write(32'h4, 32'h0000_0033, 4'h1, 1, 0, 0);
        do_read(32'h4);
        do_write(32'h0, 32'h0F0F, 4'hF, 0, 0, 1);
        do_read(32'h0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            else
                do_read(a);
        end

`ifdef LED_PWM_EN
        begin
            int on;
            do_write(32'h4, 32'h40, 4'h1, 0, 0, 0);
            do_write(32'h0, 32'hFFFF, 4'h3, 0, 0, 0);
            repeat (3) @(posedge clk);
            on = 0;
            repeat (255) begin
                @(negedge clk);
                if (led[0]) on++;
            end
            chk("pwm_duty_40", on, 64);
            do_write(32'h4, 32'h00, 4'h1, 0, 0, 0);
            repeat (3) @(posedge clk);
            on = 0;
            repeat (255) begin
                @(negedge clk);
                if (led != 16'h0) on++;
            end
            chk("pwm_duty_0", on, 0);
            @(posedge clk);
            #1;
        end
`endif

        do_write(32'h0, 32'hBEEF, 4'hF, 0, 0, 0);
        awaddr = 32'h0;
        wdata = 32'h1111;
        wstrb = 4'hF;
        awvalid = 1'b1;
        c = 0;
        f = 0;
        while (!f && c < 20) begin
            @(negedge clk);
            f = awvalid && awready;
            @(posedge clk);
            #1;
            c++;
        end
        awvalid = 1'b0;
        chk("mid_aw_accept", {31'h0, f}, 32'h1);
        reset = 1'b1;
        #1;
        chk("async_rst_ready", {29'h0, awready, wready, arready}, 32'h0);
        m_pat = RESET_LEDS;
        m_bri = 8'hFF;
        m_cnt = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_b", {31'h0, bvalid}, 32'h0);
        end
        chk("mid_rst_led", {16'h0, led}, {16'h0, RESET_LEDS});
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_b", {31'h0, bvalid}, 32'h0);
        end
        @(posedge clk);
        #1;
        do_read(32'h0);
        do_read(32'h8);
        do_read(32'h4);
        do_write(32'h0, 32'h00C3, 4'h1, 0, 2, 0);
        do_read(32'h8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/led_axi_slave.md
# led_axi_slave

AXI4-Lite slave that drives the board's 16 user LEDs and sits directly downstream of the LED-pattern master, receiving its writes to the LED register. It holds a 16-bit LED pattern register, an 8-bit brightness register, and a read-only count of accepted writes. Independent write-address and write-data acceptance, a single outstanding write response, and a single outstanding read response. An optional PWM stage dims the LED outputs.

## Interface
- RESET_LEDS, 16'h0000: reset value of the LED pattern register.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- S_AXI_AWADDR  in  32  write address; only bits [3:2] decoded.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; honoured per register.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  32  read address; bits [3:2] decoded.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- led  out  16  LED drive, active-high.

## Operation
- Register map (by addr[3:2]):
  - 0x00 LED pattern, 16 bits, R/W. WSTRB[0] gates bits [7:0]; WSTRB[1] gates bits [15:8].
  - 0x04 brightness, 8 bits, R/W. WSTRB[0] gates the write. Reset value 0xFF.
  - 0x08 write counter, 32 bits, RO. Counts OKAY writes and wraps 0xFFFFFFFF→0. A write to this address gets SLVERR, changes nothing, and is not counted.
  - 0x0C unmapped. Writes get SLVERR. Reads get SLVERR with RDATA = 0.
- Unused upper bits read as 0.
- Write channel, states W_IDLE / W_RESP:
  - W_IDLE: AWREADY = !aw_held and WREADY = !w_held. Address and data are latched independently, in either order or in the same cycle.
  - On the edge where the later of the two handshakes completes: commit the register update, increment the counter if OKAY, set BVALID = 1 with BRESP, and go to W_RESP.
  - W_RESP: AWREADY = WREADY = 0. When BVALID && BREADY: clear the held flags, BVALID → 0, go to W_IDLE.
- Read channel, states R_IDLE / R_RESP:
  - R_IDLE: ARREADY = 1. On handshake, register RDATA/RRESP, set RVALID = 1, go to R_RESP.
  - R_RESP: ARREADY = 0. When RVALID && RREADY: RVALID → 0, go to R_IDLE.
- Read and write channels are fully independent. If a read and a write commit to the same register on the same edge, the read returns the pre-write value.
- Reset mid-transaction: all handshakes are dropped, with no response. Registers return to reset values: pattern = RESET_LEDS, brightness = 0xFF, counter = 0.

## Timing
- Reset values: AWREADY = WREADY = ARREADY = 0 while reset is asserted. All three go to 1 on the first clock edge after reset deasserts.
- Also at reset: BVALID = RVALID = 0, BRESP = RRESP = 0, RDATA = 0, led = RESET_LEDS.
- Write latency: BVALID is high the cycle after the second handshake edge. The pattern register updates on that same edge.
- Read latency: RVALID is high the cycle after the AR handshake edge.
- Back-to-back throughput: one write per 2 cycles when BREADY is held high. The same applies to reads.
- led follows the pattern register with 1 cycle of registered output delay (plus PWM gating when enabled).

## Configuration
- LED_PWM_EN defined:
  - An 8-bit free-running counter counts 0..254 and wraps, giving a 255-cycle period.
  - led[i] = pattern[i] && (pwm_cnt < brightness). Brightness 0 means always off; 0xFF means always on.
- LED_PWM_EN undefined:
  - No PWM counter; led = pattern, registered.
  - 0x04 reads 0. Writes to 0x04 return OKAY, are ignored, and are still counted.

## Test plan
- After reset release, read 0x00, 0x04, 0x08 → RDATA 0x0000, 0x00FF (0 with PWM off), 0; RRESP OKAY; led = 0x0000.
- AW and W in the same cycle, write 0xAAAA to 0x00 with BREADY = 1 → BVALID the next cycle, BRESP 00, led = 0xAAAA. Then write 0x5555 → led = 0x5555 and counter reads 2.
- W presented 3 cycles before AW with WSTRB = 4'b0010, data 0x1234 to 0x00 (pattern 0x5555) → pattern 0x1255, single B response.
- Write to 0x08 and read 0x0C → BRESP 2'b10, counter unchanged; RRESP 2'b10, RDATA 0.
- Hold BREADY low for 5 cycles after a write → BVALID stays high, AWREADY/WREADY stay 0, a second write is not accepted until B completes.
- With LED_PWM_EN, brightness 0x40, pattern 0xFFFF → led high for 64 of every 255 cycles. Brightness 0 → led constantly 0.
- Assert reset mid-write, after AW is accepted but before W → BVALID never rises, pattern = RESET_LEDS, counter = 0.
